// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared types and constants for the RC4 PRGA decryptor
package rc4_pkg;

  typedef enum logic [3:0] {
    IDLE,
    READ_I,
    WAIT_I,
    READ_J,
    WAIT_J,
    WRITE_I,
    WRITE_J,
    READ_F,
    WAIT_F,
    WRITE_OUT,
    DONE
  } prga_state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LO    = 8'h61;
  localparam logic [7:0] ASCII_HI    = 8'h7A;

  // Plaintext alphabet accepted for a candidate key: space and lowercase letters.
  function automatic logic is_plain(input logic [7:0] b);
    return (b == ASCII_SPACE) || ((b >= ASCII_LO) && (b <= ASCII_HI));
  endfunction

endpackage

// File: rtl/trap_edge.sv
// rtl/trap_edge.sv - registered one-cycle pulse on each rising edge of a level input
module trap_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= level;
      pulse <= level & ~prev;
    end
  end

endmodule

// File: rtl/rc4_decryptor.sv
// rtl/rc4_decryptor.sv - RC4 PRGA over the shuffled S RAM, XORs the keystream with the
// encrypted ROM into the decrypted RAM, optionally aborting on a non-plaintext byte.
module rc4_decryptor
  import rc4_pkg::*;
#(
  parameter int RAM_WIDTH   = 8,
  parameter int RAM_LENGTH  = 8,
  parameter int MSG_LENGTH  = 32,
  parameter int MSG_ADDR_W  = 5,
  parameter int CHECK_ASCII = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  finished,
  output logic                  key_invalid,
  input  logic [RAM_WIDTH-1:0]  s_ram_out,
  output logic [RAM_LENGTH-1:0] s_address,
  output logic [RAM_WIDTH-1:0]  s_ram_in,
  output logic                  s_write_enable,
  input  logic [RAM_WIDTH-1:0]  rom_out,
  output logic [MSG_ADDR_W-1:0] rom_address,
  output logic [MSG_ADDR_W-1:0] dec_address,
  output logic [RAM_WIDTH-1:0]  dec_ram_in,
  output logic                  dec_write_enable
);

  localparam logic [MSG_ADDR_W-1:0] LAST_K = MSG_ADDR_W'(MSG_LENGTH - 1);

  prga_state_t           state;
  logic [RAM_LENGTH-1:0] i, j;
  logic [MSG_ADDR_W-1:0] k;
  logic [RAM_WIDTH-1:0]  si, sj, f, enc;
  logic                  start_pulse;
  logic                  abort;

  trap_edge u_start_edge (
    .clk   (clk),
    .reset (reset),
    .level (start),
    .pulse (start_pulse)
  );

  assign abort = (CHECK_ASCII != 0) && !is_plain(8'(f ^ enc));

  // Outputs are registered on the edge that enters a state, so each state's
  // address is already on the bus for the whole cycle of that state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      i                <= '0;
      j                <= '0;
      k                <= '0;
      si               <= '0;
      sj               <= '0;
      f                <= '0;
      enc              <= '0;
      finished         <= 1'b0;
      key_invalid      <= 1'b0;
      s_address        <= '0;
      s_ram_in         <= '0;
      s_write_enable   <= 1'b0;
      rom_address      <= '0;
      dec_address      <= '0;
      dec_ram_in       <= '0;
      dec_write_enable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_pulse) begin
            // i restarts at 0 and is pre-incremented for the first READ_I.
            key_invalid <= 1'b0;
            k           <= '0;
            j           <= '0;
            i           <= RAM_LENGTH'(1);
            s_address   <= RAM_LENGTH'(1);
            state       <= READ_I;
          end
        end
        READ_I: state <= WAIT_I;
        WAIT_I: begin
          si        <= s_ram_out;
          j         <= j + RAM_LENGTH'(s_ram_out);
          s_address <= j + RAM_LENGTH'(s_ram_out);
          state     <= READ_J;
        end
        READ_J: state <= WAIT_J;
        WAIT_J: begin
          sj             <= s_ram_out;
          s_address      <= i;
          s_ram_in       <= s_ram_out;
          s_write_enable <= 1'b1;
          state          <= WRITE_I;
        end
        WRITE_I: begin
          s_address <= j;
          s_ram_in  <= si;
          state     <= WRITE_J;
        end
        WRITE_J: begin
          s_write_enable <= 1'b0;
          s_address      <= RAM_LENGTH'(si + sj);
          rom_address    <= k;
          state          <= READ_F;
        end
        READ_F: state <= WAIT_F;
        WAIT_F: begin
          f                <= s_ram_out;
          enc              <= rom_out;
          dec_address      <= k;
          dec_ram_in       <= s_ram_out ^ rom_out;
          dec_write_enable <= 1'b1;
          state            <= WRITE_OUT;
        end
        WRITE_OUT: begin
          dec_write_enable <= 1'b0;
          if (abort || (k == LAST_K)) begin
            key_invalid <= abort;
            finished    <= 1'b1;
            state       <= DONE;
          end else begin
            k         <= k + MSG_ADDR_W'(1);
            i         <= i + RAM_LENGTH'(1);
            s_address <= i + RAM_LENGTH'(1);
            state     <= READ_I;
          end
        end
        DONE: begin
          finished <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
